// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state type.
// Imported by the interface users, the lane decoder and the responder top.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_state_e;

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite slave-port bundle between the matrix and one responder.
// HREADY is the bus-wide ready returned by the matrix.
interface ahb_lite_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        output HPROT, HMASTLOCK, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        input  HPROT, HMASTLOCK, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_slv_byte_en.sv
// Byte-lane strobe and alignment decode for one AHB transfer.
// Illegal sizes give no lanes; the caller flags them separately.
module ahb_slv_byte_en
    import ahb_lite_pkg::*;
(
    input  logic [2:0] size_q,
    input  logic [1:0] addr_q,
    output logic [3:0] strb,
    output logic       misalign
);

    // Lane select and misalignment from size and low address bits
    always_comb begin
        strb     = 4'b0000;
        misalign = 1'b0;
        case (size_q)
            HSIZE_BYTE: strb = 4'b0001 << addr_q;
            HSIZE_HALF: begin
                strb     = addr_q[1] ? 4'b1100 : 4'b0011;
                misalign = addr_q[0];
            end
            HSIZE_WORD: begin
                strb     = 4'b1111;
                misalign = |addr_q;
            end
            default: begin
                strb     = 4'b0000;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states and 2-cycle ERROR.
// Optional privilege check: define AHB_SLV_PRIV_CHECK_EN.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int          MEM_BYTES   = 4096,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] PRIV_BASE   = 32'h0000_0800
) (
    input logic HCLK,
    input logic HRESET,
    ahb_lite_sram_slave_if.slave bus
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int DEPTH = MEM_BYTES / 4;
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0] mem [DEPTH];

    ahb_state_e  state;
    logic [3:0]  cnt;
    logic [AW-1:0] addr_q;
    logic [2:0]  size_q;
    logic        write_q;
    logic [3:0]  prot_q;
    logic        hready_q;
    logic        hresp_q;

    logic          accept;
    logic [AW-1:0] off;
    logic [3:0]    strb_in_unused;
    logic          mis_in;
    logic          priv_err;
    logic          err_in;
    logic [3:0]    strb_q;
    logic          mis_q_unused;
    logic          unused_ok;

    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign off    = bus.HADDR[AW-1:0];

    ahb_slv_byte_en u_chk (
        .size_q   (bus.HSIZE),
        .addr_q   (off[1:0]),
        .strb     (strb_in_unused),
        .misalign (mis_in)
    );

    ahb_slv_byte_en u_lanes (
        .size_q   (size_q),
        .addr_q   (addr_q[1:0]),
        .strb     (strb_q),
        .misalign (mis_q_unused)
    );

`ifdef AHB_SLV_PRIV_CHECK_EN
    assign priv_err = ~bus.HPROT[1] &
                      ({{(32-AW){1'b0}}, off} >= PRIV_BASE);
`else
    assign priv_err = 1'b0;
`endif

    assign err_in = (bus.HSIZE > HSIZE_WORD) | mis_in | priv_err;

    assign unused_ok = ^{bus.HBURST, bus.HMASTLOCK, bus.HADDR[31:AW],
                         bus.HPROT, prot_q, PRIV_BASE};

    // Transfer FSM: captures the address phase and sequences the response
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            prot_q   <= 4'd0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= ST_DATA;
                        hready_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    if (accept) begin
                        addr_q  <= off;
                        size_q  <= bus.HSIZE;
                        write_q <= bus.HWRITE;
                        prot_q  <= bus.HPROT;
                        if (err_in) begin
                            state    <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= HRESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            state    <= ST_DATA;
                            hready_q <= 1'b1;
                            hresp_q  <= HRESP_OKAY;
                        end else begin
                            state    <= ST_WAIT;
                            cnt      <= WS_LOAD;
                            hready_q <= 1'b0;
                            hresp_q  <= HRESP_OKAY;
                        end
                    end else begin
                        state    <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Commit write lanes at the edge that ends an OKAY write data phase
    always_ff @(posedge HCLK) begin
        if (!HRESET && state == ST_DATA && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[addr_q[AW-1:2]][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign bus.HREADYOUT = hready_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = (state == ST_DATA && !write_q) ?
                           mem[addr_q[AW-1:2]] : 32'd0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Scoreboard bench for ahb_lite_sram_slave with a byte-array reference.
// Stimulus pushes expected responses; a monitor pops them per data phase.
module tb_ahb_lite_sram_slave;
    import ahb_lite_pkg::*;

    localparam int          MEM = 4096;
    localparam int          WS  = 3;
    localparam logic [31:0] PB  = 32'h0000_0800;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] rdata;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    logic [7:0] rm [MEM];

    ahb_lite_sram_slave_if bus ();

    ahb_lite_sram_slave #(
        .MEM_BYTES   (MEM),
        .WAIT_STATES (WS),
        .PRIV_BASE   (PB)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;
    assign bus.HREADY = bus.HREADYOUT;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endfunction

    // Reference: applies each transfer in program order to a byte array
    function automatic exp_t model(bit wr, logic [31:0] addr,
                                   logic [2:0] size, logic [3:0] prot,
                                   logic [31:0] wdata);
        exp_t e;
        int   o;
        int   nb;
        bit   priv;
        o  = int'(addr % MEM);
        priv = 1'b0;
`ifdef AHB_SLV_PRIV_CHECK_EN
        priv = (prot[1] == 1'b0) && (o >= int'(PB));
`endif
        e.rd    = !wr;
        e.rdata = 32'd0;
        e.err   = (size > 3'd2) || priv ||
                  (size == 3'd1 && (o % 2) != 0) ||
                  (size == 3'd2 && (o % 4) != 0);
        if (!e.err) begin
            nb = 1 << size;
            if (wr) begin
                for (int b = 0; b < nb; b++)
                    rm[o + b] = wdata[8 * ((o + b) % 4) +: 8];
            end else begin
                for (int b = 0; b < 4; b++)
                    e.rdata[8*b +: 8] = rm[(o / 4) * 4 + b];
            end
        end
        return e;
    endfunction

    task automatic stop_fatal(string n);
        errors++;
        $display("FAIL %s got timeout want progress", n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench aborted");
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge HCLK);
        while (!bus.HREADY) begin
            n++;
            if (n > 64) stop_fatal("hready_timeout");
            @(negedge HCLK);
        end
    endtask

    // Issue one NONSEQ transfer; data phase driven after acceptance
    task automatic xfer(bit wr, logic [31:0] addr, logic [2:0] size,
                        logic [3:0] prot, logic [31:0] wdata);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HPROT  = prot;
        wait_ready();
        @(posedge HCLK);
        #1;
        bus.HWDATA = wdata;
        sb.push_back(model(wr, addr, size, prot, wdata));
        bus.HTRANS = HTRANS_IDLE;
        bus.HSEL   = 1'b0;
    endtask

    task automatic idle_cyc(int n, bit busy);
        bus.HSEL   = 1'($urandom);
        bus.HTRANS = busy ? HTRANS_BUSY : HTRANS_IDLE;
        bus.HADDR  = $urandom;
        repeat (n) @(posedge HCLK);
        #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
    endtask

    task automatic drain();
        int n = 0;
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        while (sb.size() != 0) begin
            n++;
            if (n > 64) stop_fatal("drain_timeout");
            @(negedge HCLK);
        end
        @(posedge HCLK);
        #1;
    endtask

    // Monitor: tracks each data phase and checks it against the scoreboard
    initial begin
        bit in_dp = 1'b0;
        int w = 0;
        int e1 = 0;
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (!mon_en || HRESET) begin
                in_dp = 1'b0;
            end else begin
                if (in_dp) begin
                    if (!bus.HREADYOUT) begin
                        if (bus.HRESP) e1++;
                        else w++;
                    end else begin
                        in_dp = 1'b0;
                        if (sb.size() == 0) begin
                            chk("sb_empty", 32'd1, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("resp", 32'(bus.HRESP), 32'(e.err));
                            chk("err1_cycles", 32'(e1), e.err ? 32'd1 : 32'd0);
                            chk("wait_cycles", 32'(w), e.err ? 32'd0 : 32'(WS));
                            chk("rdata", bus.HRDATA,
                                (e.rd && !e.err) ? e.rdata : 32'd0);
                        end
                    end
                end else begin
                    chk("idle_ready", 32'(bus.HREADYOUT), 32'd1);
                    chk("idle_resp", 32'(bus.HRESP), 32'd0);
                    chk("idle_rdata", bus.HRDATA, 32'd0);
                end
                if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
                    in_dp = 1'b1;
                    w = 0;
                    e1 = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        bus.HSEL = 1'b0;
        bus.HADDR = 32'd0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
        bus.HSIZE = HSIZE_WORD;
        bus.HBURST = 3'd0;
        bus.HPROT = 4'b0011;
        bus.HMASTLOCK = 1'b0;
        bus.HWDATA = 32'd0;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_resp", 32'(bus.HRESP), 32'd0);
        chk("rst_rdata", bus.HRDATA, 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < MEM / 4; i++)
            xfer(1'b1, 32'(i * 4), HSIZE_WORD, 4'b0011, $urandom);

        xfer(1'b1, 32'h10, HSIZE_WORD, 4'b0011, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h10, HSIZE_WORD, 4'b0011, $urandom);
        xfer(1'b1, 32'h10, HSIZE_WORD, 4'b0011, 32'h1122_3344);
        xfer(1'b1, 32'h13, HSIZE_BYTE, 4'b0011, 32'hAA00_0000);
        xfer(1'b0, 32'h10, HSIZE_WORD, 4'b0011, $urandom);
        xfer(1'b0, 32'h20, HSIZE_WORD, 4'b0011, $urandom);
        xfer(1'b0, 32'h24, HSIZE_WORD, 4'b0011, $urandom);
        xfer(1'b1, 32'h20, HSIZE_WORD, 4'b0011, 32'hCAFE_F00D);
        xfer(1'b1, 32'h21, HSIZE_HALF, 4'b0011, 32'h5A5A_5A5A);
        xfer(1'b0, 32'h20, HSIZE_WORD, 4'b0011, $urandom);
        xfer(1'b1, 32'h900, HSIZE_WORD, 4'b0001, 32'h5555_AAAA);
        xfer(1'b0, 32'h900, HSIZE_WORD, 4'b0011, $urandom);
        xfer(1'b1, 32'h900, HSIZE_WORD, 4'b0011, 32'h1234_5678);
        xfer(1'b0, 32'h900, HSIZE_WORD, 4'b0011, $urandom);
        xfer(1'b1, 32'h31, HSIZE_BYTE, 4'b0011, 32'h0000_7700);
        xfer(1'b1, 32'h36, HSIZE_HALF, 4'b0011, 32'hBEEF_0000);
        xfer(1'b0, 32'h33, 3'd3, 4'b0011, $urandom);
        xfer(1'b0, 32'h30, HSIZE_WORD, 4'b0011, $urandom);
        xfer(1'b0, 32'h34, HSIZE_WORD, 4'b0011, $urandom);
        drain();

        // Reset while a write sits in its wait states: no commit
        mon_en = 1'b0;
        bus.HSEL = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HADDR = 32'h40;
        bus.HWRITE = 1'b1;
        bus.HSIZE = HSIZE_WORD;
        wait_ready();
        @(posedge HCLK);
        #1;
        bus.HWDATA = 32'h0BAD_F00D;
        bus.HSEL = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        @(negedge HCLK);
        chk("inflight_wait", 32'(bus.HREADYOUT), 32'd0);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("post_rst_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("post_rst_resp", 32'(bus.HRESP), 32'd0);
        chk("post_rst_rdata", bus.HRDATA, 32'd0);
        repeat (6) @(posedge HCLK);
        #1;
        mon_en = 1'b1;
        xfer(1'b0, 32'h40, HSIZE_WORD, 4'b0011, $urandom);

        for (int i = 0; i < 300; i++) begin
            a  = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                             : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 9) < 7 && sz <= 3'd2)
                a = a & ~((32'd1 << sz) - 32'd1);
            xfer(1'($urandom), a, sz, 4'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0)
                idle_cyc($urandom_range(1, 3), 1'($urandom));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
